// File: rtl/mrd_rdx3_ctrl_if.sv
// Bus bundle between the radix-3 stage controller and its scheduler, data RAM
// and butterfly datapath. The controller takes the master side.
interface mrd_rdx3_ctrl_if #(
    parameter int ADDR_W = 12
);
    // stage request from the scheduler
    logic                     start;
    logic [ADDR_W-1:0]        cfg_m;
    logic [ADDR_W-1:0]        cfg_base;
    logic [3:0]               cfg_exp;
    logic [1:0]               cfg_margin;
    logic                     stall;

    // RAM read side
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr0;
    logic [ADDR_W-1:0]        rd_addr1;
    logic [ADDR_W-1:0]        rd_addr2;

    // datapath side
    logic                     dp_in_val;
    logic [3:0]               dp_exp_in;
    logic [1:0]               dp_margin_in;
    logic                     dp_out_val;
    logic signed [17:0]       dp_dout_real [0:4];
    logic signed [17:0]       dp_dout_imag [0:4];
    logic [3:0]               dp_exp_out;

    // RAM write side
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr0;
    logic [ADDR_W-1:0]        wr_addr1;
    logic [ADDR_W-1:0]        wr_addr2;

    // stage status
    logic                     busy;
    logic                     done;
    logic [3:0]               exp_result;
    logic [1:0]               margin_out;
    logic                     seq_err;

    modport master (
        input  start, cfg_m, cfg_base, cfg_exp, cfg_margin, stall,
        input  dp_out_val, dp_dout_real, dp_dout_imag, dp_exp_out,
        output rd_en, rd_addr0, rd_addr1, rd_addr2,
        output dp_in_val, dp_exp_in, dp_margin_in,
        output wr_en, wr_addr0, wr_addr1, wr_addr2,
        output busy, done, exp_result, margin_out, seq_err
    );

    modport slave (
        output start, cfg_m, cfg_base, cfg_exp, cfg_margin, stall,
        output dp_out_val, dp_dout_real, dp_dout_imag, dp_exp_out,
        input  rd_en, rd_addr0, rd_addr1, rd_addr2,
        input  dp_in_val, dp_exp_in, dp_margin_in,
        input  wr_en, wr_addr0, wr_addr1, wr_addr2,
        input  busy, done, exp_result, margin_out, seq_err
    );
endinterface

// File: rtl/mrd_rdx3_ctrl.sv
// Radix-3 FFT stage sequencer. Issues M butterflies (legs base+k, base+M+k,
// base+2M+k), delay-matches valid and addresses through RAM read latency and
// datapath latency to form in-place writes, and measures output headroom
// (redundant sign bits, clamped to 3) for the next stage's block exponent.
module mrd_rdx3_ctrl #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1,
    parameter int DP_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mrd_rdx3_ctrl_if.master   bus
);
    localparam int STAGES = RD_LAT + DP_LAT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                          state, state_nxt;
    logic                            ready;
    logic                            accept;
    logic                            issue;
    logic                            done_c;
    logic                            pipe_drained;
    logic                            in_stage;

    logic [ADDR_W-1:0]               k;
    logic [ADDR_W-1:0]               m_q;
    logic [ADDR_W-1:0]               m_last;
    logic [ADDR_W-1:0]               base_q;
    logic [3:0]                      exp_q;
    logic [1:0]                      marg_q;

    logic [2:0][ADDR_W-1:0]          issue_addr;
    logic [STAGES:1]                 vld_pipe;
    logic [STAGES:1][2:0][ADDR_W-1:0] addr_pipe;

    logic [1:0]                      acc;
    logic [1:0]                      word_min;
    logic                            seq_err_q;
    logic [3:0]                      exp_res_q;
    logic [1:0]                      marg_res_q;
    logic                            unused_words;

    // Redundant sign bits below bit17, stopping at first mismatch, clamped to 3.
    function automatic logic [1:0] rsb(input logic [17:0] w);
        logic [1:0] n;
        n = 2'd0;
        if (w[16] == w[17]) begin
            n = 2'd1;
            if (w[15] == w[17]) begin
                n = 2'd2;
                if (w[14] == w[17]) n = 2'd3;
            end
        end
        return n;
    endfunction

    // start on the very edge that releases reset must not be taken, so
    // acceptance is armed one cycle after reset deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready <= 1'b0;
        else        ready <= 1'b1;
    end

    assign accept       = ready && bus.start && (state == IDLE);
    assign m_last       = m_q - 1'b1;
    assign in_stage     = (state == RUN) || (state == DRAIN);
    // Looking at stages 1..STAGES-1 lets DONE follow the final write directly.
    assign pipe_drained = ~|vld_pipe[STAGES-1:1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic plus the issue strobe and done pulse.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (bus.cfg_m == '0) ? DONE : RUN;
            end
            RUN: begin
                issue = !bus.stall;
                if (issue && (k == m_last)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pipe_drained) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage configuration latch and butterfly counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            base_q <= '0;
            exp_q  <= '0;
            marg_q <= '0;
            k      <= '0;
        end else if (accept) begin
            m_q    <= bus.cfg_m;
            base_q <= bus.cfg_base;
            exp_q  <= bus.cfg_exp;
            marg_q <= bus.cfg_margin;
            k      <= '0;
        end else if (issue) begin
            k      <= k + 1'b1;
        end
    end

    // Leg addresses wrap naturally at 2^ADDR_W.
    always_comb begin
        issue_addr[0] = base_q + k;
        issue_addr[1] = base_q + m_q + k;
        issue_addr[2] = base_q + {m_q[ADDR_W-2:0], 1'b0} + k;
    end

    // Free-running delay line for valid and addresses; stall only gates issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], issue};
            addr_pipe <= {addr_pipe[STAGES-1:1], issue_addr};
        end
    end

    // Smallest headroom among the six live datapath words this cycle.
    always_comb begin
        word_min = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (rsb(bus.dp_dout_real[i]) < word_min) word_min = rsb(bus.dp_dout_real[i]);
            if (rsb(bus.dp_dout_imag[i]) < word_min) word_min = rsb(bus.dp_dout_imag[i]);
        end
    end

    // Margin accumulator and sticky sequencing check against expected writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            seq_err_q <= 1'b0;
        end else if (accept) begin
            acc       <= 2'd3;
            seq_err_q <= 1'b0;
        end else begin
            if (bus.dp_out_val && (word_min < acc)) acc <= word_min;
            if (in_stage && (bus.dp_out_val != vld_pipe[STAGES])) seq_err_q <= 1'b1;
        end
    end

    // Stage results captured in the done cycle and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_res_q  <= '0;
            marg_res_q <= '0;
        end else if (state == DONE) begin
            exp_res_q  <= bus.dp_exp_out;
            marg_res_q <= acc;
        end
    end

    assign unused_words = ^{bus.dp_dout_real[3], bus.dp_dout_real[4],
                            bus.dp_dout_imag[3], bus.dp_dout_imag[4]};

    assign bus.rd_en        = issue;
    assign bus.rd_addr0     = issue_addr[0];
    assign bus.rd_addr1     = issue_addr[1];
    assign bus.rd_addr2     = issue_addr[2];
    assign bus.dp_in_val    = vld_pipe[RD_LAT];
    assign bus.dp_exp_in    = exp_q;
    assign bus.dp_margin_in = marg_q;
    assign bus.wr_en        = vld_pipe[STAGES];
    assign bus.wr_addr0     = addr_pipe[STAGES][0];
    assign bus.wr_addr1     = addr_pipe[STAGES][1];
    assign bus.wr_addr2     = addr_pipe[STAGES][2];
    // busy stays high through the done cycle and falls together with done.
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_c;
    // Results are visible during the done pulse itself, then held.
    assign bus.exp_result   = (state == DONE) ? bus.dp_exp_out : exp_res_q;
    assign bus.margin_out   = (state == DONE) ? acc : marg_res_q;
    assign bus.seq_err      = seq_err_q;
endmodule

// File: tb/tb_mrd_rdx3_ctrl.sv
// Directed bench for the radix-3 stage sequencer: cycle-by-cycle issue/write
// timing, stall, address wrap, margin/exponent results, ignored starts,
// empty stage, sequencing error and mid-stage reset.
module tb_mrd_rdx3_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic inj = 1'b0;
    logic [3:0] dpq;
    int n_chk = 0;
    int n_pass = 0;
    int iss [0:7];

    mrd_rdx3_ctrl_if #(.ADDR_W(12)) bus ();

    mrd_rdx3_ctrl #(.ADDR_W(12), .RD_LAT(1), .DP_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: fixed 4-cycle valid delay, plus a spurious-valid injector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dpq <= '0;
        else        dpq <= {dpq[2:0], bus.dp_in_val};
    end
    assign bus.dp_out_val = dpq[3] | inj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_words(input logic [17:0] w);
        for (int i = 0; i < 5; i++) begin
            bus.dp_dout_real[i] = w;
            bus.dp_dout_imag[i] = w;
        end
    endtask

    // Runs one stage; iss[] holds the hand-derived issue cycle of each butterfly.
    task automatic run_stage(input int m, input int base, input int ncyc, input int done_cyc,
                             input logic [31:0] stall_mask, input int inj_cyc, input int sp_cyc);
        int exp_rd [0:31];
        int exp_wr [0:31];
        for (int c = 0; c < 32; c++) begin
            exp_rd[c] = -1;
            exp_wr[c] = -1;
        end
        for (int j = 0; j < m; j++) begin
            exp_rd[iss[j]]     = j;
            exp_wr[iss[j] + 5] = j;
        end
        @(negedge clk);
        bus.cfg_m    = 12'(m);
        bus.cfg_base = 12'(base);
        bus.start    = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start    = (c == sp_cyc);
            bus.cfg_base = (c == sp_cyc) ? 12'd100 : 12'(base);
            bus.stall    = stall_mask[c];
            inj          = (c == inj_cyc);
            @(negedge clk);
            chk("rd_en", 32'(bus.rd_en), 32'(exp_rd[c] >= 0));
            if (exp_rd[c] >= 0) begin
                chk("rd_addr0", 32'(bus.rd_addr0), 32'((base + exp_rd[c]) % 4096));
                chk("rd_addr1", 32'(bus.rd_addr1), 32'((base + m + exp_rd[c]) % 4096));
                chk("rd_addr2", 32'(bus.rd_addr2), 32'((base + 2 * m + exp_rd[c]) % 4096));
            end
            chk("dp_in_val", 32'(bus.dp_in_val), 32'(exp_rd[c-1] >= 0));
            chk("wr_en", 32'(bus.wr_en), 32'(exp_wr[c] >= 0));
            if (exp_wr[c] >= 0) begin
                chk("wr_addr0", 32'(bus.wr_addr0), 32'((base + exp_wr[c]) % 4096));
                chk("wr_addr1", 32'(bus.wr_addr1), 32'((base + m + exp_wr[c]) % 4096));
                chk("wr_addr2", 32'(bus.wr_addr2), 32'((base + 2 * m + exp_wr[c]) % 4096));
            end
            chk("done", 32'(bus.done), 32'(c == done_cyc));
            chk("busy", 32'(bus.busy), 32'(c <= done_cyc));
            chk("seq_err", 32'(bus.seq_err), 32'(inj_cyc != 0 && c > inj_cyc));
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        inj       = 1'b0;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.cfg_m      = '0;
        bus.cfg_base   = '0;
        bus.cfg_exp    = 4'd5;
        bus.cfg_margin = 2'd2;
        bus.stall      = 1'b0;
        bus.dp_exp_out = 4'd7;
        set_words(18'h00FFF);

        // reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_margin_out", 32'(bus.margin_out), 0);
        chk("rst_exp_result", 32'(bus.exp_result), 0);

        // start coincident with reset release is ignored
        bus.cfg_m = 12'd4;
        bus.start = 1'b1;
        rst_n     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("rel_start_busy", 32'(bus.busy), 0);
        chk("rel_start_rd_en", 32'(bus.rd_en), 0);

        // M=4, base 0, no stall
        iss = '{1, 2, 3, 4, 0, 0, 0, 0};
        run_stage(4, 0, 12, 10, 32'h0, 0, 0);
        chk("t1_margin_out", 32'(bus.margin_out), 3);
        chk("t1_exp_result", 32'(bus.exp_result), 7);
        chk("t1_dp_exp_in", 32'(bus.dp_exp_in), 5);
        chk("t1_dp_margin_in", 32'(bus.dp_margin_in), 2);

        // stall in cycles 2-3, one word without headroom
        bus.dp_dout_imag[2] = 18'h1FFFF;
        iss = '{1, 4, 5, 6, 0, 0, 0, 0};
        run_stage(4, 0, 14, 12, 32'b1100, 0, 0);
        chk("t2_margin_out", 32'(bus.margin_out), 0);
        set_words(18'h00FFF);

        // address wrap at 2^12
        iss = '{1, 2, 3, 0, 0, 0, 0, 0};
        run_stage(3, 4090, 11, 9, 32'h0, 0, 0);
        chk("t3_margin_out", 32'(bus.margin_out), 3);

        // start pulsed during RUN is ignored
        iss = '{1, 2, 3, 4, 0, 0, 0, 0};
        run_stage(4, 0, 12, 10, 32'h0, 0, 2);

        // empty stage: done one cycle after start, no traffic
        run_stage(0, 0, 3, 1, 32'h0, 0, 0);

        // spurious dp_out_val during RUN sets seq_err until the next start
        iss = '{1, 2, 3, 4, 0, 0, 0, 0};
        run_stage(4, 0, 12, 10, 32'h0, 2, 0);
        run_stage(0, 0, 3, 1, 32'h0, 0, 0);
        chk("t6_margin_out", 32'(bus.margin_out), 3);

        // reset asserted during DRAIN
        @(negedge clk);
        bus.cfg_m    = 12'd4;
        bus.cfg_base = '0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_wr_en", 32'(bus.wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
        chk("mid_rst_dp_in_val", 32'(bus.dp_in_val), 0);
        chk("mid_rst_wr_addr0", 32'(bus.wr_addr0), 0);
        chk("mid_rst_dp_exp_in", 32'(bus.dp_exp_in), 0);
        chk("mid_rst_margin_out", 32'(bus.margin_out), 0);
        chk("mid_rst_exp_result", 32'(bus.exp_result), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_done", 32'(bus.done), 0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_done", 32'(bus.done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
